// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl : main control FSM of the multicycle CPU datapath          |
// | rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl_sig,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic       mem_fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12, S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int             CW    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW:0]    LIMIT = (CW + 1)'(WAIT_LIMIT);
    localparam logic [CW:0]    ONE   = (CW + 1)'(1);

    state_t        cur;
    state_t        nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW:0]   wait_inc;
    logic          fault;
    logic          pc_write;
    logic          branch;
    logic          waiting;

    // Outputs are decoded from the registered state; strobes gated by
    // mem_ready, zero, op or funct are qualified in the same cycle.
    always_comb begin
        nxt          = cur;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_ctrl_sig = ALU_ADD;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        illegal      = 1'b0;
        waiting      = 1'b0;
        case (cur)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                waiting   = !mem_ready;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE:     nxt = S_EXEC;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                waiting = !mem_ready;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                waiting   = !mem_ready;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                nxt       = S_ALUWB;
                case (funct)
                    FN_ADD: alu_ctrl_sig = ALU_ADD;
                    FN_SUB: alu_ctrl_sig = ALU_SUB;
                    FN_AND: alu_ctrl_sig = ALU_AND;
                    FN_OR:  alu_ctrl_sig = ALU_OR;
                    FN_SLT: alu_ctrl_sig = ALU_SLT;
                    default: begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_ctrl_sig = ALU_SUB;
                pc_src       = 2'b01;
                branch       = 1'b1;
                nxt          = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                nxt      = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RST;
        endcase

        // The cycle that would make the wait count hit the limit moves to HALT.
        wait_inc = {1'b0, wait_cnt} + ONE;
        if (WAIT_LIMIT != 0 && waiting && wait_inc == LIMIT) nxt = S_HALT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= S_RST;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt == S_HALT) fault <= 1'b1;
            if (nxt != cur || !waiting) wait_cnt <= '0;
            else                        wait_cnt <= wait_inc[CW-1:0];
        end
    end

    assign pc_en     = pc_write | (branch & zero);
    assign mem_fault = fault;
    assign state     = cur;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl : directed per-cycle checks of the multicycle control   |
// | rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl_sig;
    logic       reg_dst, mem_to_reg, reg_write, illegal, mem_fault;
    logic [3:0] state;

    int n_vec  = 0;
    int n_miss = 0;

    multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl_sig(alu_ctrl_sig),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .mem_fault(mem_fault), .state(state)
    );

    always #5 clk = ~clk;

    // Strobe word: {mem_req, mem_write, iord, ir_write, pc_en, reg_write, illegal, mem_fault}
    localparam logic [7:0] B_NONE = 8'h00, B_FETCH = 8'h98, B_FWAIT = 8'h80, B_MRD = 8'hA0;
    localparam logic [7:0] B_MWR  = 8'hE0, B_WB    = 8'h04, B_PC    = 8'h08, B_ILL = 8'h02;
    localparam logic [7:0] B_FLT  = 8'h01;
    // Select word: {pc_src, alu_src_a, alu_src_b, alu_ctrl_sig, reg_dst, mem_to_reg}
    localparam logic [9:0] X_DEF = 10'h008, X_FETCH = 10'h028, X_DEC = 10'h068, X_IMM = 10'h0C8;
    localparam logic [9:0] X_MWB = 10'h009, X_RADD  = 10'h088, X_AWB = 10'h00A, X_BR  = 10'h198;
    localparam logic [9:0] X_J   = 10'h208;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, ADDI = 6'h08, J = 6'h02, BEQ = 6'h04;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, check away from the edge, then advance.
    task automatic cyc(input logic rs, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic rdy, input logic [3:0] est,
                       input logic [7:0] estb, input logic [9:0] esel, input string tag);
        reset     = rs;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = rdy;
        #2;
        check_eq({tag, "/state"}, 32'(state), 32'(est));
        check_eq({tag, "/strobes"},
                 32'({mem_req, mem_write, iord, ir_write, pc_en, reg_write, illegal, mem_fault}),
                 32'(estb));
        check_eq({tag, "/selects"},
                 32'({pc_src, alu_src_a, alu_src_b, alu_ctrl_sig, reg_dst, mem_to_reg}),
                 32'(esel));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input logic z, input string tag);
        cyc(1'b0, o, f, z, 1'b1, 4'd1, B_FETCH, X_FETCH, {tag, "_fetch"});
        cyc(1'b0, o, f, z, 1'b1, 4'd2, B_NONE,  X_DEC,   {tag, "_decode"});
    endtask

    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [9:0] sel_tab[5] = '{10'h088, 10'h098, 10'h080, 10'h084, 10'h09C};

    initial begin
        @(posedge clk);
        #1;
        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) cyc(1'b1, LW, 6'h0, 1'b0, 1'b1, 4'd0, B_NONE, X_DEF, "reset_held");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd0, B_NONE, X_DEF, "reset_release");

        // lw
        fetch_decode(LW, 6'h0, 1'b0, "lw");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd3, B_NONE, X_IMM, "lw_memadr");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd4, B_MRD,  X_DEF, "lw_memrd");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd5, B_WB,   X_MWB, "lw_memwb");
        // sw
        fetch_decode(SW, 6'h0, 1'b0, "sw");
        cyc(1'b0, SW, 6'h0, 1'b0, 1'b1, 4'd3, B_NONE, X_IMM, "sw_memadr");
        cyc(1'b0, SW, 6'h0, 1'b0, 1'b1, 4'd6, B_MWR,  X_DEF, "sw_memwr");
        // R-type, every supported funct
        for (int i = 0; i < 5; i++) begin
            fetch_decode(RT, fn_tab[i], 1'b0, "rtype");
            cyc(1'b0, RT, fn_tab[i], 1'b0, 1'b1, 4'd7, B_NONE, sel_tab[i], "rtype_exec");
            cyc(1'b0, RT, fn_tab[i], 1'b0, 1'b1, 4'd8, B_WB,   X_AWB,      "rtype_aluwb");
        end
        // addi
        fetch_decode(ADDI, 6'h0, 1'b0, "addi");
        cyc(1'b0, ADDI, 6'h0, 1'b0, 1'b1, 4'd10, B_NONE, X_IMM, "addi_ex");
        cyc(1'b0, ADDI, 6'h0, 1'b0, 1'b1, 4'd11, B_WB,   X_DEF, "addi_wb");
        // j
        fetch_decode(J, 6'h0, 1'b0, "j");
        cyc(1'b0, J, 6'h0, 1'b0, 1'b1, 4'd12, B_PC, X_J, "j_jump");
        // beq taken, then not taken
        fetch_decode(BEQ, 6'h0, 1'b1, "beq_t");
        cyc(1'b0, BEQ, 6'h0, 1'b1, 1'b1, 4'd9, B_PC,   X_BR, "beq_taken");
        fetch_decode(BEQ, 6'h0, 1'b0, "beq_nt");
        cyc(1'b0, BEQ, 6'h0, 1'b0, 1'b1, 4'd9, B_NONE, X_BR, "beq_not_taken");

        // lw with memory stalls: 3 cycles in FETCH, 2 in MEMRD; ready ignored elsewhere.
        for (int i = 0; i < 3; i++) cyc(1'b0, LW, 6'h0, 1'b0, 1'b0, 4'd1, B_FWAIT, X_FETCH, "stall_fetch");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd1, B_FETCH, X_FETCH, "stall_fetch_done");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b0, 4'd2, B_NONE,  X_DEC,   "stall_decode");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b0, 4'd3, B_NONE,  X_IMM,   "stall_memadr");
        for (int i = 0; i < 2; i++) cyc(1'b0, LW, 6'h0, 1'b0, 1'b0, 4'd4, B_MRD, X_DEF, "stall_memrd");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd4, B_MRD,   X_DEF,   "stall_memrd_done");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd5, B_WB,    X_MWB,   "stall_memwb");

        // Illegal op, then illegal funct.
        cyc(1'b0, 6'h3F, 6'h0, 1'b0, 1'b1, 4'd1, B_FETCH, X_FETCH, "ill_op_fetch");
        cyc(1'b0, 6'h3F, 6'h0, 1'b0, 1'b1, 4'd2, B_ILL,   X_DEC,   "ill_op_decode");
        fetch_decode(RT, 6'h3F, 1'b0, "ill_fn");
        cyc(1'b0, RT, 6'h3F, 1'b0, 1'b1, 4'd7, B_ILL, X_RADD, "ill_fn_exec");

        // Reset in the middle of a lw write-back aborts it.
        fetch_decode(LW, 6'h0, 1'b0, "abort");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd3, B_NONE, X_IMM, "abort_memadr");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd4, B_MRD,  X_DEF, "abort_memrd");
        cyc(1'b1, LW, 6'h0, 1'b0, 1'b1, 4'd0, B_NONE, X_DEF, "abort_reset");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd0, B_NONE, X_DEF, "abort_release");

        // Watchdog: sw never acknowledged.
        fetch_decode(SW, 6'h0, 1'b0, "wd");
        cyc(1'b0, SW, 6'h0, 1'b0, 1'b1, 4'd3, B_NONE, X_IMM, "wd_memadr");
        for (int i = 0; i < 4; i++) cyc(1'b0, SW, 6'h0, 1'b0, 1'b0, 4'd6, B_MWR, X_DEF, "wd_memwr_wait");
        cyc(1'b0, SW, 6'h0, 1'b0, 1'b0, 4'd13, B_FLT, X_DEF, "wd_halt");
        for (int i = 0; i < 3; i++) cyc(1'b0, LW, 6'h0, 1'b1, 1'b1, 4'd13, B_FLT, X_DEF, "wd_halt_hold");
        cyc(1'b1, LW, 6'h0, 1'b0, 1'b1, 4'd0, B_NONE, X_DEF, "wd_reset");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd0, B_NONE, X_DEF, "wd_release");
        cyc(1'b0, LW, 6'h0, 1'b0, 1'b1, 4'd1, B_FETCH, X_FETCH, "wd_refetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle variant of the CPU datapath.
- Sequences one shared instruction/data memory, the ALU and the register file over several cycles per instruction.
- Issues per-cycle mux selects and write strobes, plus a req/ready memory handshake.
- Sits beside the datapath inside the cpu block.
- Decodes lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.

Parameters:
- WAIT_LIMIT, 16: max consecutive cycles a memory request may wait for mem_ready before fault; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction [31:26] from the instruction register
- funct  in  6  instruction [5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a write
- iord  out  1  memory address select: 0 = pc, 1 = ALU result register
- ir_write  out  1  instruction register load
- pc_en  out  1  pc load enable = pc_write | (branch & zero)
- pc_src  out  2  pc source: 00 = ALU result, 01 = ALU out register, 10 = jump target
- alu_src_a  out  1  ALU A input: 0 = pc, 1 = rs register
- alu_src_b  out  2  ALU B input: 00 = rt register, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_ctrl_sig  out  3  ALU op: add 010, sub 110, and 000, or 001, slt 111
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back source: 0 = ALU, 1 = memory data
- reg_write  out  1  register file write strobe
- illegal  out  1  one-cycle pulse on an unsupported op or funct
- mem_fault  out  1  sticky; set on watchdog expiry
- state  out  4  current state encoding, for debug

Behaviour:
- Default output values are all 0, alu_ctrl_sig = 010. A state sets only the outputs listed for it.
- State encodings: RST 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12, HALT 13.
- While reset is high: state = RST, all outputs at default.
- RST: goes to FETCH unconditionally on the next edge. Nothing is fetched in the reset-release cycle.
- FETCH: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, pc_src = 00.
  - ir_write and pc_write are asserted only in the cycle with mem_ready = 1 (Mealy-qualified); the state then goes to DECODE.
  - Otherwise the state holds with strobes low.
- DECODE: alu_src_a = 0, alu_src_b = 11, add (computes the branch target). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op: illegal = 1 this cycle, next state FETCH.
- MEMADR: alu_src_a = 1, alu_src_b = 10, add. Next state MEMRD for lw, MEMWR for sw (op held stable by the instruction register).
- MEMRD: mem_req = 1, iord = 1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next state FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1. Holds until mem_ready, then goes to FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00. alu_ctrl_sig from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Other funct: alu_ctrl_sig = 010, illegal = 1, next state FETCH (no write-back).
  - Legal funct: next state ALUWB.
- ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, sub, pc_src = 01, branch = 1, so pc_en = zero. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, add. Next state ADDIWB.
- ADDIWB: reg_dst = 0, reg_write = 1. Next state FETCH.
- JUMP: pc_src = 10, pc_write = 1. Next state FETCH.
- Watchdog:
  - A wait counter counts cycles in FETCH/MEMRD/MEMWR with mem_ready = 0. It clears on mem_ready and on every state change.
  - When WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT: go to HALT and set mem_fault.
  - HALT: all other outputs at default, mem_fault = 1. Held until reset.
- Latency with mem_ready tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction aborts the instruction immediately: no strobe completes, state = RST.

Test Plan:
- Reset high 3 cycles, then low, mem_ready = 1 -> all outputs 0 during reset; state 0 then 1; first ir_write/pc_en in the second cycle after release.
- Stream lw, sw, add, addi, j (op 23h, 2Bh, 00h/funct 20h, 08h, 02h), mem_ready = 1 -> state sequences 1-2-3-4-5, 1-2-3-6, 1-2-7-8, 1-2-10-11, 1-2-12; reg_write only in states 5/8/11; mem_write only in state 6.
- beq with zero = 1, then beq with zero = 0 -> in state 9, pc_en = 1 with pc_src = 01 for the first; pc_en = 0 for the second.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD -> state holds; ir_write, pc_en and reg_write remain 0 while waiting; total 10 cycles.
- op = 3Fh, and separately R-type with funct = 3Fh -> one-cycle illegal pulse in DECODE (resp. EXEC); return to FETCH; no reg_write.
- WAIT_LIMIT = 4, mem_ready held 0 in MEMWR -> HALT after 4 wait cycles; mem_fault stays 1 and mem_req stays 0 until reset; reset returns state to 0 with mem_fault cleared.
